// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing block.
//   DATA_W / OP_W : operand/result and opcode widths
//   OP_*          : opcode encodings understood by alu_9bit
//   state_t       : control FSM encoding used by alu_share_arbiter
package alu_pkg;

  localparam int DATA_W  = 9;
  localparam int OP_W    = 4;
  localparam int NUM_REQ = 2;

  localparam logic [OP_W-1:0] OP_ZERO   = 4'b0000;
  localparam logic [OP_W-1:0] OP_PASSA  = 4'b0001;
  localparam logic [OP_W-1:0] OP_PASSB  = 4'b0010;
  localparam logic [OP_W-1:0] OP_NOTA   = 4'b0011;
  localparam logic [OP_W-1:0] OP_INCA   = 4'b0100;
  localparam logic [OP_W-1:0] OP_INCB   = 4'b0101;
  localparam logic [OP_W-1:0] OP_UNDEF  = 4'b0110;
  localparam logic [OP_W-1:0] OP_ADD    = 4'b0111;
  localparam logic [OP_W-1:0] OP_SUB    = 4'b1000;
  localparam logic [OP_W-1:0] OP_AND    = 4'b1001;
  localparam logic [OP_W-1:0] OP_OR     = 4'b1010;
  localparam logic [OP_W-1:0] OP_XOR    = 4'b1011;
  localparam logic [OP_W-1:0] OP_SHL    = 4'b1100;
  localparam logic [OP_W-1:0] OP_SHR    = 4'b1101;
  localparam logic [OP_W-1:0] OP_SWAP   = 4'b1110;
  localparam logic [OP_W-1:0] OP_PARITY = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two operand issuers and the shared ALU.
//   req0_* / req1_* : valid/ready request channels (operands a, b, opcode)
//   rsp_*           : single valid/ready result channel tagged with id, err
// master = requesters/consumer side, slave = alu_share_arbiter side.
interface alu_share_arbiter_if;
  import alu_pkg::*;

  logic              req0_valid, req0_ready;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic [OP_W-1:0]   req0_op;
  logic              req1_valid, req1_ready;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic [OP_W-1:0]   req1_op;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id, rsp_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_9bit.sv
// Purely combinational 9-bit ALU.
//   a, b : operands
//   op   : opcode (alu_pkg OP_*)
//   y    : result, truncated to DATA_W bits
//   err  : opcode is OP_UNDEF (y forced to 0)
module alu_9bit
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y,
  output logic              err
);

  // Shift distances of DATA_W or more push every bit out.
  logic shift_big;
  assign shift_big = (b >= DATA_W'(DATA_W));

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_ZERO:   y = '0;
      OP_PASSA:  y = a;
      OP_PASSB:  y = b;
      OP_NOTA:   y = ~a;
      OP_INCA:   y = a + DATA_W'(1);
      OP_INCB:   y = b + DATA_W'(1);
      OP_UNDEF:  err = 1'b1;
      OP_ADD:    y = a + b;
      OP_SUB:    y = a - b;
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_XOR:    y = a ^ b;
      OP_SHL:    y = shift_big ? '0 : (a << b[3:0]);
      OP_SHR:    y = shift_big ? '0 : (a >> b[3:0]);
      OP_SWAP:   y = {1'b0, a[3:0], a[7:4]};
      OP_PARITY: y = {{(DATA_W-1){1'b0}}, ^a};
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one alu_9bit between two requesters.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : alu_share_arbiter_if.slave (two request channels, one
//              response channel tagged with requester id and err)
// Flow: IDLE grants+captures -> EXEC registers the ALU result -> RESP holds
// it until consumed; consuming in RESP may grant the next request in the
// same cycle, giving one result every two cycles.
module alu_share_arbiter
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus
);

  state_t state, state_nxt;

  logic                            last_grant;
  logic [DATA_W-1:0]               opnd_a, opnd_b;
  logic [OP_W-1:0]                 opnd_op;
  logic                            opnd_id;

  logic                            rsp_valid, rsp_id, rsp_err;
  logic [DATA_W-1:0]               rsp_data;

  logic [NUM_REQ-1:0]              req_vld;
  logic [NUM_REQ-1:0][DATA_W-1:0]  req_a, req_b;
  logic [NUM_REQ-1:0][OP_W-1:0]    req_op;

  logic                            can_grant, grant, gnt_id;
  logic [DATA_W-1:0]               alu_y;
  logic                            alu_err;

  assign req_vld = {bus.req1_valid, bus.req0_valid};
  assign req_a   = {bus.req1_a,     bus.req0_a};
  assign req_b   = {bus.req1_b,     bus.req0_b};
  assign req_op  = {bus.req1_op,    bus.req0_op};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    can_grant = 1'b0;
    // Both valid: the one not served last wins; otherwise the lone valid one.
    gnt_id    = (&req_vld) ? ~last_grant : req_vld[1];
    case (state)
      ST_IDLE: can_grant = 1'b1;
      ST_RESP: can_grant = bus.rsp_ready;
      default: can_grant = 1'b0;
    endcase
    // Gate on rst so readies read 0 while reset is held.
    grant = can_grant & (|req_vld) & ~rst;
    case (state)
      ST_IDLE: if (grant) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_nxt = grant ? ST_EXEC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.req0_ready = grant & ~gnt_id;
  assign bus.req1_ready = grant &  gnt_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      opnd_a     <= '0;
      opnd_b     <= '0;
      opnd_op    <= '0;
      opnd_id    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (grant) begin
        last_grant <= gnt_id;
        opnd_a     <= req_a[gnt_id];
        opnd_b     <= req_b[gnt_id];
        opnd_op    <= req_op[gnt_id];
        opnd_id    <= gnt_id;
      end
      if (state == ST_EXEC) begin
        rsp_valid <= 1'b1;
        rsp_data  <= alu_y;
        rsp_err   <= alu_err;
        rsp_id    <= opnd_id;
      end else if (state == ST_RESP && bus.rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  alu_9bit u_alu (
    .a   (opnd_a),
    .b   (opnd_b),
    .op  (opnd_op),
    .y   (alu_y),
    .err (alu_err)
  );

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_err   = rsp_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic,
// all checked against a transaction-level model of the sharing rules.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_arbiter_if bus();
  alu_share_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic       v;
    logic [8:0] a;
    logic [8:0] b;
    logic [3:0] op;
  } req_t;

  typedef struct {
    logic [8:0] a, b;
    logic [3:0] op;
    logic [8:0] y;
    logic       e;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  // Model: one transaction at most in flight; m_vis = result on the bus.
  bit         m_last, m_out, m_vis;
  logic [9:0] m_pend, m_show;
  bit         m_pend_id, m_show_id;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic v, input logic [8:0] a, input logic [8:0] b,
                              input logic [3:0] op);
    req_t r;
    r.v = v; r.a = a; r.b = b; r.op = op;
    return r;
  endfunction

  function automatic logic [9:0] alu_ref(input logic [8:0] a, input logic [8:0] b,
                                         input logic [3:0] op);
    int ia, ib, r;
    bit e;
    ia = int'(a); ib = int'(b); r = 0; e = 1'b0;
    case (op)
      4'd0:  r = 0;
      4'd1:  r = ia;
      4'd2:  r = ib;
      4'd3:  r = 511 - ia;
      4'd4:  r = (ia + 1) % 512;
      4'd5:  r = (ib + 1) % 512;
      4'd6:  begin r = 0; e = 1'b1; end
      4'd7:  r = (ia + ib) % 512;
      4'd8:  r = (ia - ib + 512) % 512;
      4'd9:  r = ia & ib;
      4'd10: r = ia | ib;
      4'd11: r = ia ^ ib;
      4'd12: r = (ib >= 9) ? 0 : (ia * (1 << ib)) % 512;
      4'd13: r = (ib >= 9) ? 0 : ia / (1 << ib);
      4'd14: r = (ia % 16) * 16 + (ia / 16) % 16;
      default: r = $countones(a) % 2;
    endcase
    return {e, r[8:0]};
  endfunction

  task automatic model_reset();
    m_last = 1'b1; m_out = 1'b0; m_vis = 1'b0;
    m_pend = '0; m_show = '0; m_pend_id = 1'b0; m_show_id = 1'b0;
  endtask

  task automatic drive(input req_t r0, input req_t r1, input bit rr);
    bus.req0_valid = r0.v; bus.req0_a = r0.a; bus.req0_b = r0.b; bus.req0_op = r0.op;
    bus.req1_valid = r1.v; bus.req1_a = r1.a; bus.req1_b = r1.b; bus.req1_op = r1.op;
    bus.rsp_ready  = rr;
  endtask

  // One cycle: drive just after negedge, check, advance model, go to next negedge.
  task automatic step(input req_t r0, input req_t r1, input bit rr,
                      output bit g0, output bit g1);
    bit consume, can, acc, eid, nvis;
    drive(r0, r1, rr);
    #1;
    consume = m_vis && rr;
    can     = !m_out || consume;
    acc     = can && (r0.v || r1.v);
    eid     = (r0.v && r1.v) ? !m_last : r1.v;
    chk("req0_ready", bus.req0_ready, acc && !eid);
    chk("req1_ready", bus.req1_ready, acc && eid);
    chk("rsp_valid", bus.rsp_valid, m_vis);
    if (m_vis) begin
      chk("rsp_data", bus.rsp_data, m_show[8:0]);
      chk("rsp_err", bus.rsp_err, m_show[9]);
      chk("rsp_id", bus.rsp_id, m_show_id);
    end
    g0 = bus.req0_ready;
    g1 = bus.req1_ready;
    nvis = (m_out && !m_vis) || (m_vis && !consume);
    if (m_out && !m_vis) begin
      m_show = m_pend; m_show_id = m_pend_id;
    end
    if (acc) begin
      m_pend    = eid ? alu_ref(r1.a, r1.b, r1.op) : alu_ref(r0.a, r0.b, r0.op);
      m_pend_id = eid;
      m_last    = eid;
      m_out     = 1'b1;
    end else if (consume) begin
      m_out = 1'b0;
    end
    m_vis = nvis;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, bus.rsp_valid, 1'b0);
    chk({tag, "_data"}, bus.rsp_data, 9'h000);
    chk({tag, "_id"}, bus.rsp_id, 1'b0);
    chk({tag, "_err"}, bus.rsp_err, 1'b0);
    chk({tag, "_rdy"}, {bus.req1_ready, bus.req0_ready}, 2'b00);
  endtask

  req_t idle, both0, both1;
  bit   g0, g1;

  initial begin
    vec_t tbl[7];
    int   seq[$];
    int   c0, c1;
    logic [8:0] hd;
    logic hid, herr;
    req_t h[2];
    bit   hold[2];

    tbl = '{'{9'h0FF, 9'h001, 4'b0111, 9'h100, 1'b0},
            '{9'h0A5, 9'h000, 4'b1110, 9'h05A, 1'b0},
            '{9'h007, 9'h000, 4'b1111, 9'h001, 1'b0},
            '{9'h001, 9'd9,   4'b1100, 9'h000, 1'b0},
            '{9'h000, 9'h001, 4'b1000, 9'h1FF, 1'b0},
            '{9'h100, 9'h003, 4'b1101, 9'h020, 1'b0},
            '{9'h123, 9'h045, 4'b0110, 9'h000, 1'b1}};
    idle  = mk(1'b0, 9'h0, 9'h0, 4'h0);
    both0 = mk(1'b1, 9'h011, 9'h022, 4'b0111);
    both1 = mk(1'b1, 9'h1F0, 9'h00F, 4'b1011);
    model_reset();

    // Reset state, with both requesters asking.
    rst = 1'b1;
    drive(both0, both1, 1'b1);
    #2;
    check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Contention: grants must alternate starting at req0.
    for (int i = 0; i < 8; i++) begin
      step(both0, both1, 1'b1, g0, g1);
      if (g0) seq.push_back(0);
      if (g1) seq.push_back(1);
    end
    chk("cont_count", seq.size(), 4);
    for (int i = 0; i < seq.size() && i < 4; i++) chk("cont_order", seq[i], i % 2);
    repeat (3) step(idle, idle, 1'b1, g0, g1);

    // Single requests covering the edge opcodes.
    foreach (tbl[i]) begin
      step(mk(1'b1, tbl[i].a, tbl[i].b, tbl[i].op), idle, 1'b1, g0, g1);
      chk("op_gnt", g0, 1'b1);
      step(idle, idle, 1'b1, g0, g1);
      chk("op_valid", bus.rsp_valid, 1'b1);
      chk("op_data", bus.rsp_data, tbl[i].y);
      chk("op_err", bus.rsp_err, tbl[i].e);
      chk("op_id", bus.rsp_id, 1'b0);
      step(idle, idle, 1'b1, g0, g1);
    end

    // Back-pressure: result must hold while req1 waits.
    step(mk(1'b1, 9'h003, 9'h004, 4'b0111), idle, 1'b0, g0, g1);
    step(idle, idle, 1'b0, g0, g1);
    hd = bus.rsp_data; hid = bus.rsp_id; herr = bus.rsp_err;
    chk("bp_data0", hd, 9'h007);
    for (int i = 0; i < 5; i++) begin
      step(idle, both1, 1'b0, g0, g1);
      chk("bp_hold", {herr, hid, hd}, {bus.rsp_err, bus.rsp_id, bus.rsp_data});
    end
    step(idle, both1, 1'b1, g0, g1);
    chk("bp_gnt1", g1, 1'b1);
    repeat (3) step(idle, idle, 1'b1, g0, g1);

    // Reset while EXEC, then while RESP.
    for (int k = 0; k < 2; k++) begin
      step(both0, idle, 1'b0, g0, g1);
      if (k == 1) step(idle, idle, 1'b0, g0, g1);
      drive(both0, both1, 1'b1);
      rst = 1'b1;
      #1;
      check_reset_outputs(k == 0 ? "rst_exec" : "rst_resp");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(both0, both1, 1'b1, g0, g1);
      chk("rst_cont0", g0, 1'b1);
      repeat (3) step(idle, idle, 1'b1, g0, g1);
    end

    // Lone requester 1 gets every grant.
    c0 = 0; c1 = 0;
    for (int i = 0; i < 5; i++) begin
      step(idle, mk(1'b1, 9'(i), 9'h002, 4'b0111), 1'b1, g0, g1);
      c0 += int'(g0); c1 += int'(g1);
    end
    chk("fair_req1", c1, 3);
    chk("fair_req0", c0, 0);
    repeat (3) step(idle, idle, 1'b1, g0, g1);

    // Random traffic; ungranted requests keep their payload.
    hold[0] = 1'b0; hold[1] = 1'b0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!hold[i])
          h[i] = mk($urandom_range(0, 99) < 55, 9'($urandom),
                    $urandom_range(0, 1) ? 9'($urandom_range(0, 12)) : 9'($urandom),
                    4'($urandom_range(0, 15)));
      end
      step(h[0], h[1], $urandom_range(0, 99) < 70, g0, g1);
      hold[0] = h[0].v && !g0;
      hold[1] = h[1].v && !g1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
